// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timing/control counters (up-counter and
// down_counter_timer): the timer FSM state type, the reload mode encodings
// and the default counter width used by both counters.
// ----------------------------------------------------------------------------
package timer_pkg;

    // Default counter/period width shared with the loadable up-counter.
    localparam int TIMER_WIDTH = 8;

    // Mode bit latched on start: one-shot stops at zero, periodic reloads.
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage : timer_pkg

// File: rtl/down_counter_timer.sv
// ----------------------------------------------------------------------------
// down_counter_timer
// Loadable synchronous down-counter timer. A start strobe latches a period N
// and counts N, N-1, ..., 0. tc pulses for the single cycle in which count is
// 0. In one-shot mode the timer then parks in DONE with done high. In periodic
// mode it reloads N, so tc repeats every N+1 cycles.
//
// Optional build macro: DOWN_COUNTER_TIMER_PAUSE_EN adds a pause input that
// freezes counting, reload and tc generation while in RUN.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   strobe: latch load_val/periodic and (re)start counting
//   stop      in   strobe: abort to IDLE, count holds (wins over start)
//   periodic  in   sampled with start: 1 = auto-reload, 0 = one-shot
//   pause     in   (macro only) hold the count while in RUN
//   load_val  in   period value N, sampled with start
//   count     out  current count (registered)
//   busy      out  high while in RUN (registered)
//   tc        out  terminal-count pulse, coincident with count==0 in RUN
//   done      out  one-shot completion level (registered)
// ----------------------------------------------------------------------------
module down_counter_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
`ifdef DOWN_COUNTER_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             paused;

`ifdef DOWN_COUNTER_TIMER_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            period_q <= '0;
            mode_q   <= MODE_ONESHOT;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
        end
    end

    // tc is computed one edge early (from the value count is about to take)
    // so the registered pulse lines up exactly with count==0.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        tc_d     = tc_q;
        done_d   = done_q;

        if (stop) begin
            // Stop beats start; in IDLE it changes nothing.
            if (state_q != IDLE) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tc_d    = 1'b0;
                done_d  = 1'b0;
            end
        end else if (start) begin
            state_d  = RUN;
            count_d  = load_val;
            period_d = load_val;
            mode_d   = periodic;
            busy_d   = 1'b1;
            tc_d     = (load_val == '0);
            done_d   = 1'b0;
        end else if (state_q == RUN) begin
            if (paused) begin
                tc_d = 1'b0;
`ifdef DOWN_COUNTER_TIMER_PAUSE_EN
            end else if ((count_q == '0) && !tc_q) begin
                // Resuming while parked at zero: the expiry pulse was
                // suppressed during the pause, so deliver it now.
                tc_d = 1'b1;
`endif
            end else if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
                tc_d    = (count_q == WIDTH'(1));
            end else if (mode_q == MODE_PERIODIC) begin
                count_d = period_q;
                tc_d    = (period_q == '0);
            end else begin
                state_d = DONE;
                busy_d  = 1'b0;
                tc_d    = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// ----------------------------------------------------------------------------
// tb_down_counter_timer
// Directed testbench for down_counter_timer with hand-computed expectations.
// Build with DOWN_COUNTER_TIMER_PAUSE_EN defined to also exercise pause.
// ----------------------------------------------------------------------------
module tb_down_counter_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       busy;
    logic       tc;
    logic       done;
`ifdef DOWN_COUNTER_TIMER_PAUSE_EN
    logic       pause;
`endif

    int checks   = 0;
    int failures = 0;

    down_counter_timer #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
`ifdef DOWN_COUNTER_TIMER_PAUSE_EN
        .pause    (pause),
`endif
        .load_val (load_val),
        .count    (count),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle with the given strobes applied; outputs are sampled
    // 1 time unit after the edge and the strobes are then released.
    task automatic applyStimulus(input logic s, input logic p, input logic per,
                                 input logic [7:0] lv);
        start    = s;
        stop     = p;
        periodic = per;
        load_val = lv;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expCount,
                               input logic expBusy, input logic expTc,
                               input logic expDone);
        checks++;
        assert ({count, busy, tc, done} === {expCount, expBusy, expTc, expDone})
        else begin
            failures++;
            $error("[TB] FAIL %s: observed count=%0d busy=%b tc=%b done=%b, expected count=%0d busy=%b tc=%b done=%b",
                   tag, count, busy, tc, done, expCount, expBusy, expTc, expDone);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        load_val = 8'd0;
`ifdef DOWN_COUNTER_TIMER_PAUSE_EN
        pause    = 1'b0;
`endif
        // Reset state
        tick();
        tick();
        checkOutput("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        checkOutput("idle_after_reset", 8'd0, 1'b0, 1'b0, 1'b0);

        // One-shot N=5: 5,4,3,2,1,0 then DONE
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd5);
        checkOutput("os5_c1", 8'd5, 1'b1, 1'b0, 1'b0);
        for (int k = 4; k >= 0; k--) begin
            tick();
            checkOutput($sformatf("os5_cnt%0d", k), 8'(k), 1'b1, (k == 0), 1'b0);
        end
        tick();
        checkOutput("os5_done", 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("os5_done_hold", 8'd0, 1'b0, 1'b0, 1'b1);

        // Periodic N=3 started from DONE: 3,2,1,0 repeating, tc on 4/8/12
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3);
        checkOutput("per3_c1", 8'd3, 1'b1, 1'b0, 1'b0);
        for (int k = 2; k <= 12; k++) begin
            tick();
            checkOutput($sformatf("per3_c%0d", k), 8'(3 - ((k - 1) % 4)), 1'b1,
                        ((k % 4) == 0), 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("per3_stop", 8'd0, 1'b0, 1'b0, 1'b0);

        // N=0 one-shot and periodic
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("os0_c1", 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("os0_done", 8'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("done_stop", 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd0);
        checkOutput("per0_c1", 8'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            checkOutput($sformatf("per0_c%0d", k), 8'd0, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("per0_stop", 8'd0, 1'b0, 1'b0, 1'b0);

        // stop+start at count 2: stop wins, count frozen
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd5);
        checkOutput("ss_c1", 8'd5, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("ss_at2", 8'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd9);
        checkOutput("ss_stopwins", 8'd2, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("ss_idle_hold", 8'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("idle_stop_noop", 8'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd7);
        checkOutput("start7", 8'd7, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("start7_c2", 8'd6, 1'b1, 1'b0, 1'b0);

        // Retrigger in RUN with N=0, then reset mid-count
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("retrig0", 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("retrig0_done", 8'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd4);
        checkOutput("restart4", 8'd4, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("rst_midrun", 8'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Periodic N=255: 256-cycle tc period, no wrap except by reload
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd255);
        checkOutput("p255_c1", 8'd255, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 255; i++) begin
            tick();
            checkOutput($sformatf("p255_i%0d", i), 8'(255 - i), 1'b1, (i == 255), 1'b0);
        end
        tick();
        checkOutput("p255_reload", 8'd255, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("p255_after_reload", 8'd254, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("p255_stop", 8'd254, 1'b0, 1'b0, 1'b0);

`ifdef DOWN_COUNTER_TIMER_PAUSE_EN
        // Pause at count 2 for three cycles, then resume to expiry
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd4);
        checkOutput("pz_c1", 8'd4, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("pz_at2", 8'd2, 1'b1, 1'b0, 1'b0);
        pause = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checkOutput($sformatf("pz_hold%0d", k), 8'd2, 1'b1, 1'b0, 1'b0);
        end
        pause = 1'b0;
        tick();
        checkOutput("pz_res1", 8'd1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("pz_res0", 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("pz_done", 8'd0, 1'b0, 1'b0, 1'b1);

        // Pause while sitting at zero in periodic mode
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd1);
        checkOutput("pzero_c1", 8'd1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("pzero_tc", 8'd0, 1'b1, 1'b1, 1'b0);
        pause = 1'b1;
        tick();
        checkOutput("pzero_hold1", 8'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("pzero_hold2", 8'd0, 1'b1, 1'b0, 1'b0);
        pause = 1'b0;
        tick();
        checkOutput("pzero_resume_tc", 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("pzero_reload", 8'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("pzero_stop", 8'd1, 1'b0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_down_counter_timer

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable synchronous down-counter timer: the counting-down counterpart of the team's 8-bit loadable up-counter with terminal count.
- Latches a period value and counts down to zero, then flags terminal count.
- Runs one-shot or auto-reloading periodic.
- Sits beside the up-counter in the timing/control datapath and produces timeouts and periodic ticks for downstream FSMs.

Parameters:
- WIDTH, 8, counter/period width in bits.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset: synchronous, active-high; clock clk.
- start  input  1  one-cycle strobe; latches load_val and starts/restarts counting.
- stop  input  1  one-cycle strobe; abort to IDLE, count holds.
- periodic  input  1  sampled with start: 1 = auto-reload, 0 = one-shot.
- load_val  input  WIDTH  period value N, sampled on start.
- count  output  WIDTH  current count (registered).
- busy  output  1  high in RUN (registered).
- tc  output  1  terminal-count pulse, high exactly in the cycles where count==0 in RUN (registered).
- done  output  1  one-shot completion level (registered).

Behaviour:
- Reset (rst=1 at edge): state=IDLE, count=0, period=0, mode=0, busy=0, tc=0, done=0.
- Reset overrides everything, including mid-count.
- Priority per edge: rst > stop > start > counting.
- States: IDLE, RUN, DONE. Encoding is a 2-bit enum.
- IDLE:
  - count holds.
  - start: count<=load_val, period<=load_val, mode<=periodic, busy<=1, done<=0, go to RUN.
  - stop is a no-op.
- RUN:
  - Each edge count<=count-1 while count!=0.
  - tc<=1 on the edge that makes next count==0, so tc is coincident with count==0.
  - load_val=0 gives count=0 and tc=1 in the first cycle after start.
- RUN with count==0, periodic mode:
  - Next edge reloads count<=period, tc<=0, stays in RUN.
  - Period of tc = N+1 cycles. N=0 gives tc high every cycle.
- RUN with count==0, one-shot mode:
  - Next edge goes to DONE, tc<=0, busy<=0, done<=1, count holds 0.
- DONE:
  - done stays high.
  - start behaves as in IDLE (clears done).
  - stop returns to IDLE and clears done.
- start in RUN: restarts immediately with the new load_val/periodic (retrigger). tc<=1 only if the new load_val==0.
- stop in RUN: IDLE, busy<=0, tc<=0, count frozen at its current value.
- Simultaneous stop+start: stop wins, start is ignored.
- No wrap below zero: count never decrements past 0.
- Arithmetic is unsigned, WIDTH bits. N=2^WIDTH-1 (255) gives a 256-cycle period.
- Latency: start edge to first count value is 1 cycle. tc is high for exactly 1 cycle per expiry.

Optional Feature:
- Macro: DOWN_COUNTER_TIMER_PAUSE_EN.
- With the macro: adds input pause (1 bit).
  - In RUN with pause=1: count, tc-generation and the reload freeze. tc is forced 0 while paused.
  - State stays RUN and busy stays 1.
  - rst, stop and start still act while paused.
  - Counting resumes from the held value on the first edge with pause=0.
  - If paused at count==0, tc reasserts on resume.
- Without the macro: no pause port; behaviour as above.

Decomposition:
- Shared package timer_pkg:
  - state enum type timer_state_t {IDLE, RUN, DONE}.
  - localparam MODE_ONESHOT=0, MODE_PERIODIC=1.
  - default WIDTH constant shared with the up-counter.
- No sub-module needed: one FSM plus one counter register. The down-count/zero-detect datapath may be split into down_count_core (count, period, tc) if reused, but the default is a single module.

Test Plan:
- Reset, then start=1, load_val=5, periodic=0 -> count 5,4,3,2,1,0 on cycles 1-6; tc=1 only on cycle 6; cycle 7 done=1, busy=0, count=0.
- start, load_val=3, periodic=1, run 12 cycles -> count 3,2,1,0,3,2,1,0,...; tc=1 on cycles 4, 8, 12; done stays 0.
- load_val=0 one-shot -> cycle 1 count=0, tc=1; cycle 2 DONE, done=1. Periodic with load_val=0 -> tc=1 every cycle.
- Mid-count at count=2: stop+start together -> IDLE, count holds 2, busy=0. Then start load_val=7 -> count 7 next cycle. rst asserted during RUN -> all outputs 0 next cycle.
- load_val=255 periodic -> 256 cycles between tc pulses; count never below 0 or wraps to 255 except by reload.
- With DOWN_COUNTER_TIMER_PAUSE_EN: load_val=4, pause high 3 cycles at count=2 -> count stays 2, tc=0, busy=1; on release count 1,0 with tc on 0.
